inv_shift_rows_stream: RTL and testbench



---
 rtl/aes_pkg.sv | 19 +
 rtl/inv_shift_rows_col.sv | 22 ++
 rtl/inv_shift_rows_stream.sv | 98 +++++++++
 tb/tb_inv_shift_rows_stream.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES state types and the ShiftRows column-rotation helper.
package aes_pkg;

   localparam int BYTE     = 8;
   localparam int WORD     = 32;
   localparam int SENTENCE = 128;
   localparam int NB_COLS  = 4;
   localparam int NB_ROWS  = 4;

   // Column 0 is state_t[0]; within a column row 0 occupies the top byte.
   typedef logic [NB_COLS-1:0][WORD-1:0] state_t;

   // Source column for output byte (r,c): dir=1 forward ShiftRows, dir=0 inverse.
   function automatic logic [1:0] rot_col(input logic [1:0] r, input logic [1:0] c,
                                          input logic dir);
      return dir ? (c + r) : (c - r);
   endfunction

endpackage

// File: rtl/inv_shift_rows_col.sv
// Combinational (Inv)ShiftRows for one output column of a buffered 4-column bank.
module inv_shift_rows_col
   import aes_pkg::*;
(
   input  state_t          bank,
   input  logic [1:0]      col,
   input  logic            dir,
   output logic [WORD-1:0] word
);

   logic [1:0] src;

   always_comb begin
      word = '0;
      src  = '0;
      for (int unsigned r = 0; r < NB_ROWS; r++) begin
         src = rot_col(2'(r), col, dir);
         word[WORD-1-r*BYTE -: BYTE] = bank[src][WORD-1-r*BYTE -: BYTE];
      end
   end

endmodule

// File: rtl/inv_shift_rows_stream.sv
// Word-serial AES InvShiftRows with ping-pong block buffers on valid/ready streams.
// Optional SHIFT_ROWS_BIDIR_EN adds per-block in_fwd to select forward ShiftRows.
module inv_shift_rows_stream
   import aes_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [WORD-1:0] in_word,
`ifdef SHIFT_ROWS_BIDIR_EN
   input  logic            in_fwd,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic [WORD-1:0] out_word,
   output logic            out_last
);

   state_t     bank_q [2];
   state_t     bank_d [2];
   logic [1:0] full_q, full_d;
   logic [1:0] dir_q, dir_d;
   logic       wbank_q, wbank_d;
   logic       rbank_q, rbank_d;
   logic [1:0] wcnt_q, wcnt_d;
   logic [1:0] rcnt_q, rcnt_d;
   logic       wr_en, rd_en;
   logic       in_dir;

`ifdef SHIFT_ROWS_BIDIR_EN
   assign in_dir = in_fwd;
`else
   assign in_dir = 1'b0;
`endif

   // Write and read always target different banks, so full-flag set/clear never collide.
   always_comb begin
      bank_d    = bank_q;
      full_d    = full_q;
      dir_d     = dir_q;
      wbank_d   = wbank_q;
      rbank_d   = rbank_q;
      wcnt_d    = wcnt_q;
      rcnt_d    = rcnt_q;
      in_ready  = ~full_q[wbank_q];
      out_valid = full_q[rbank_q];
      out_last  = (rcnt_q == 2'd3);
      wr_en     = in_valid & in_ready;
      rd_en     = out_valid & out_ready;

      if (wr_en) begin
         bank_d[wbank_q][wcnt_q] = in_word;
         if (wcnt_q == 2'd0) dir_d[wbank_q] = in_dir;
         wcnt_d = wcnt_q + 2'd1;
         if (wcnt_q == 2'd3) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
         end
      end

      if (rd_en) begin
         rcnt_d = rcnt_q + 2'd1;
         if (rcnt_q == 2'd3) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_q  <= '{default: '0};
         full_q  <= '0;
         dir_q   <= '0;
         wbank_q <= 1'b0;
         rbank_q <= 1'b0;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
      end else begin
         bank_q  <= bank_d;
         full_q  <= full_d;
         dir_q   <= dir_d;
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
      end
   end

   inv_shift_rows_col u_col (
      .bank (bank_q[rbank_q]),
      .col  (rcnt_q),
      .dir  (dir_q[rbank_q]),
      .word (out_word)
   );

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Self-checking bench for inv_shift_rows_stream: byte-matrix reference model plus literal vectors.
module tb_inv_shift_rows_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        in_fwd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic        out_last;

   always #5 clk = ~clk;

   inv_shift_rows_stream dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
`ifdef SHIFT_ROWS_BIDIR_EN
      .in_fwd    (in_fwd),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_last  (out_last)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [31:0] exp_q [$];
   logic [31:0] obs_q [$];
   logic        obs_last_q [$];
   int          obs_cyc_q [$];
   logic [31:0] part [4];
   int          part_n = 0;
   bit          part_fwd = 1'b0;
   int          acc_cnt = 0;
   int          cyc = 0;
   bit          b2b_mon = 1'b0;
   int          stall_cnt = 0;
   bit          rand_rdy = 1'b0;

   logic [31:0] blk1 [4];
   logic [31:0] inv1 [4];
   logic [31:0] fwd1 [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: view the block as a 4x4 byte matrix and rotate each row by its index.
   function automatic logic [31:0] model_col(input logic [31:0] blk [4], input int c, input bit fwd);
      logic [7:0]  st [4][4];
      logic [31:0] res;
      int          src;
      for (int r = 0; r < 4; r++)
         for (int cc = 0; cc < 4; cc++)
            st[r][cc] = 8'(blk[cc] >> (24 - 8*r));
      res = '0;
      for (int r = 0; r < 4; r++) begin
         src = fwd ? (c + r) % 4 : (c - r + 4) % 4;
         res = {res[23:0], st[r][src]};
      end
      return res;
   endfunction

   always @(negedge clk) begin
      int nfull;
      cyc++;
      if (rst) begin
         exp_q.delete();
         part_n = 0;
      end else begin
         nfull = (exp_q.size() + 3) / 4;
         check("in_ready", 32'(in_ready), 32'(nfull < 2));
         check("out_valid", 32'(out_valid), 32'(nfull > 0));
         if (out_valid && nfull > 0) begin
            check("out_word", out_word, exp_q[0]);
            check("out_last", 32'(out_last), 32'(exp_q.size() % 4 == 1));
         end
         if (b2b_mon && !in_ready) stall_cnt++;
         if (out_valid && out_ready) begin
            obs_q.push_back(out_word);
            obs_last_q.push_back(out_last);
            obs_cyc_q.push_back(cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         if (in_valid && in_ready) begin
            acc_cnt++;
            if (part_n == 0) part_fwd = in_fwd;
            part[part_n] = in_word;
            part_n++;
            if (part_n == 4) begin
               for (int c = 0; c < 4; c++) exp_q.push_back(model_col(part, c, part_fwd));
               part_n = 0;
            end
         end
      end
   end

   task automatic send_word(input logic [31:0] w, input logic f);
      int n = 0;
      in_valid = 1'b1;
      in_word  = w;
      in_fwd   = f;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            break;
         end
         n++;
         if (n > 2000) begin
            check("send_timeout", 32'd1, 32'd0);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_obs(input int n);
      int k = 0;
      while (obs_q.size() < n && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("obs_count", 32'(obs_q.size()), 32'(n));
   endtask

   task automatic wait_empty();
      int k = 0;
      while (exp_q.size() != 0 && k < 5000) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic clear_obs();
      obs_q.delete();
      obs_last_q.delete();
      obs_cyc_q.delete();
   endtask

   task automatic check_lit_block(input string name, input logic [31:0] lit [4]);
      for (int i = 0; i < 4; i++) begin
         if (obs_q.size() > i) begin
            check({name, "_word"}, obs_q[i], lit[i]);
            check({name, "_last"}, 32'(obs_last_q[i]), 32'(i == 3));
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0;
      blk1 = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
      inv1 = '{32'h000d0a07, 32'h04010e0b, 32'h0805020f, 32'h0c090603};
      fwd1 = '{32'h00050a0f, 32'h04090e03, 32'h080d0207, 32'h0c01060b};

      rst = 1'b1; in_valid = 1'b0; in_word = '0; in_fwd = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_out_word", out_word, 32'd0);

      // Single block with literal expectations and latency
      out_ready = 1'b1;
      clear_obs();
      for (int i = 0; i < 3; i++) send_word(blk1[i], 1'b0);
      check("lat_before", 32'(out_valid), 32'd0);
      send_word(blk1[3], 1'b0);
      check("lat_after", 32'(out_valid), 32'd1);
      wait_obs(4);
      check_lit_block("single", inv1);
      if (obs_cyc_q.size() == 4) check("single_span", 32'(obs_cyc_q[3] - obs_cyc_q[0]), 32'd3);

      // Back-to-back: 8 blocks, both sides always ready
      wait_empty();
      clear_obs();
      stall_cnt = 0;
      b2b_mon = 1'b1;
      for (int i = 0; i < 32; i++)
         send_word({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)} ^ 32'h5a000000, 1'b0);
      wait_obs(32);
      b2b_mon = 1'b0;
      check("b2b_stalls", 32'(stall_cnt), 32'd0);
      if (obs_cyc_q.size() == 32) check("b2b_span", 32'(obs_cyc_q[31] - obs_cyc_q[0]), 32'd31);

      // Backpressure: three blocks offered with the sink stalled
      wait_empty();
      clear_obs();
      out_ready = 1'b0;
      acc0 = acc_cnt;
      fork
         begin
            for (int i = 0; i < 4; i++) send_word(blk1[i], 1'b0);
            for (int i = 0; i < 8; i++) send_word(32'hc0de0000 + 32'(i * 32'h01010101), 1'b0);
         end
      join_none
      repeat (20) begin @(posedge clk); #1; end
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_accepted", 32'(acc_cnt - acc0), 32'd8);
      check("bp_out_word", out_word, inv1[0]);
      repeat (3) begin @(posedge clk); #1; end
      check("bp_hold_word", out_word, inv1[0]);
      check("bp_hold_last", 32'(out_last), 32'd0);
      out_ready = 1'b1;
      wait fork;
      wait_obs(12);
      check_lit_block("bp_first", inv1);
      wait_empty();

      // Reset mid-block discards the partial block
      clear_obs();
      send_word(32'hdeadbeef, 1'b0);
      send_word(32'hcafef00d, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) send_word(blk1[i], 1'b0);
      wait_obs(4);
      repeat (6) begin @(posedge clk); #1; end
      check("mid_rst_count", 32'(obs_q.size()), 32'd4);
      check_lit_block("mid_rst", inv1);

      // Random gaps and sink stalls over 100 blocks
      clear_obs();
      rand_rdy = 1'b1;
      fork
         while (rand_rdy) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
         end
      join_none
      for (int i = 0; i < 400; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         send_word($urandom, 1'b0);
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      wait_empty();
      check("rand_count", 32'(obs_q.size()), 32'd400);

`ifdef SHIFT_ROWS_BIDIR_EN
      // Forward direction, then in_fwd on columns 1..3 must be ignored
      clear_obs();
      send_word(blk1[0], 1'b1);
      for (int i = 1; i < 4; i++) send_word(blk1[i], 1'b0);
      wait_obs(4);
      check_lit_block("fwd", fwd1);
      clear_obs();
      send_word(blk1[0], 1'b0);
      for (int i = 1; i < 4; i++) send_word(blk1[i], 1'b1);
      wait_obs(4);
      check_lit_block("inv_dir", inv1);
      wait_empty();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
